maxpool_relu: RTL and testbench
===============================

# maxpool_relu

2×2 stride-2 max-pooling plus ReLU stage sitting directly downstream of `conv_layer_1` and upstream of `conv_layer_2`. It consumes the three 12-bit signed feature-map streams that `conv_layer_1` emits in raster order. It produces three pooled, rectified streams at one quarter the pixel count. It needs only a half-row line buffer per channel and tolerates bubbles in the input valid.

## Interface
Parameters:
- `DATA_W`, 12: signed sample width, input and output.
- `MAP_W`, 24: input feature-map width. Must be even; elaboration error otherwise.
- `MAP_H`, 24: input feature-map height. Must be even; elaboration error otherwise.

Ports:
- `clk`, in, 1: clock. All logic is rising-edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `valid_in`, in, 1: one input pixel (all three channels) present this cycle.
- `conv_in_1` / `conv_in_2` / `conv_in_3`, in, `DATA_W` signed: channel samples from `conv_layer_1`.
- `pool_out_1` / `pool_out_2` / `pool_out_3`, out, `DATA_W` signed: pooled, ReLU'd samples, always ≥ 0.
- `valid_out`, out, 1: `pool_out_*` valid this cycle.
- `frame_done`, out, 1: one-cycle pulse coincident with the last `valid_out` of a frame.

## Operation
- Counters `col` (0..`MAP_W`-1) and `row` (0..`MAP_H`-1) advance only on `valid_in`.
  - `col` wraps to 0 and increments `row`.
  - At (`MAP_H`-1, `MAP_W`-1) both wrap to 0, so the next frame starts with no idle cycle.
- Per channel, on `valid_in`:
  - Even `col`: capture the sample into hold register `h`.
  - Odd `col`: compute `pm = max(h, in)` using a signed compare.
  - Even row, odd col: write `pm` to `lbuf[col>>1]`. `lbuf` has `MAP_W`/2 entries.
  - Odd row, odd col: `m = max(lbuf[col>>1], pm)`; output `relu(m)`, where a negative value becomes 0 and otherwise passes unchanged.
- Each frame yields exactly (`MAP_W`/2)·(`MAP_H`/2) outputs (144 at defaults), in raster order of the pooled map.
- `valid_in` low: no state changes. `valid_out` is low on the following cycle, and `pool_out_*` hold their last value.
- Reset, including mid-frame: counters, `h`, and outputs go to 0. `lbuf` contents are don't-care, because every entry is rewritten before it is read. Any partial frame is discarded, and the next `valid_in` is treated as pixel (0,0).
- No backpressure. The downstream stage must accept one output per cycle.

## Timing
- Reset values: `pool_out_*` = 0, `valid_out` = 0, `frame_done` = 0.
- Latency: `valid_out` rises exactly 1 cycle after the `valid_in` carrying the bottom-right pixel (odd row, odd col) of a window. The outputs are registered.
- Throughput: one input per cycle sustained. Output rate is at most one per cycle, in bursts of `MAP_W`/2 on alternating cycles during odd rows.
- `frame_done` is high only in the same cycle as the `valid_out` for input pixel (`MAP_H`-1, `MAP_W`-1).
- `lbuf` is written and read at the same address only on different rows, so it has no read/write hazard. A simple 1R1W array or registers is acceptable.
- Reset asserted in the same cycle as `valid_in`: reset wins, and the sample is dropped.

## Structure
- Shared package `cnn_pkg` holds `DATA_W`, the channel count (3), and a `relu` function. `conv_layer_1`, `conv_layer_2`, and this block use the same widths from it.
- Sub-module `maxpool_channel`, instantiated three times.
  - Inside each instance: `h`, `lbuf`, the compare tree, ReLU, and the output register.
  - Control inputs: `col[0]`, `row[0]`, `col>>1`, `valid_in`.
- The top level owns the counters, `valid_out`, and `frame_done`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs and `valid_in`=1. Required: all outputs 0 throughout, and the first frame after release is correct.
- Constant frame, all channels 5, `valid_in` continuous for 576 cycles. Required: 144 `valid_out` pulses, all outputs 5; first pulse 1 cycle after input #26 (row 1, col 1); `frame_done` only on pulse 144.
- Ramp, ch1 = `row`·24 + `col`, ch2 = the negation of that, ch3 = −7. Required:
  - Output (r,c) on ch1 = (2r+1)·24 + 2c+1; the first output is 25.
  - ch2 all 0.
  - ch3 all 0.
- Signed extremes: a window of {−3, 4, −2048, 2047} on ch1 and a window of {−1, −2, −2048, −5} on ch2. Required: ch1 outputs 2047, ch2 outputs 0.
- Bubbles: the ramp frame with `valid_in` toggled in a pseudo-random pattern at about 50% duty. Required: a value sequence identical to the continuous run, and each `valid_out` exactly 1 cycle after its window-completing `valid_in`.
- Mid-frame reset: apply reset after 100 inputs, then a full ramp frame, then a second frame back-to-back. Required: exactly 288 outputs after reset, correct values, and 2 `frame_done` pulses.

Source files
------------

// File: rtl/cnn_pkg.sv
// Widths and helpers shared by the conv/pool pipeline stages.
package cnn_pkg;
   localparam int DATA_W = 12;
   localparam int NUM_CH = 3;

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : x;
   endfunction
endpackage

// File: rtl/maxpool_channel.sv
// One channel of 2x2 max-pool + ReLU: pair hold register, half-row line buffer, output register.
module maxpool_channel
   import cnn_pkg::*;
#(
   parameter int MAP_W = 24,
   parameter int HCW   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic                     col_odd,
   input  logic                     row_odd,
   input  logic [HCW-1:0]           half_col,
   input  logic signed [DATA_W-1:0] sample,
   output logic signed [DATA_W-1:0] pool_out
);

   logic signed [DATA_W-1:0] h;
   logic signed [DATA_W-1:0] pm;
   logic signed [DATA_W-1:0] m;
   logic signed [DATA_W-1:0] lbuf_rd;
   logic signed [DATA_W-1:0] lbuf [MAP_W/2];

   assign pm      = (sample > h) ? sample : h;
   assign lbuf_rd = lbuf[half_col];
   assign m       = (lbuf_rd > pm) ? lbuf_rd : pm;

   // Line buffer needs no reset: every entry is rewritten on an even row before the odd row reads it.
   always_ff @(posedge clk) begin
      if (rst_n && valid_in && col_odd && !row_odd)
         lbuf[half_col] <= pm;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h        <= '0;
         pool_out <= '0;
      end else if (valid_in) begin
         if (!col_odd)
            h <= sample;
         else if (row_odd)
            pool_out <= relu(m);
      end
   end

endmodule

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 max-pool + ReLU over three raster-order feature-map streams.
module maxpool_relu
   import cnn_pkg::*;
#(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int MAP_W  = 24,
   parameter int MAP_H  = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic signed [DATA_W-1:0] conv_in_1,
   input  logic signed [DATA_W-1:0] conv_in_2,
   input  logic signed [DATA_W-1:0] conv_in_3,
   output logic signed [DATA_W-1:0] pool_out_1,
   output logic signed [DATA_W-1:0] pool_out_2,
   output logic signed [DATA_W-1:0] pool_out_3,
   output logic                     valid_out,
   output logic                     frame_done
);

   localparam int CW  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
   localparam int RW  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
   localparam int HCW = (MAP_W > 2) ? $clog2(MAP_W / 2) : 1;

   if ((MAP_W % 2) != 0 || MAP_W < 2) begin : g_bad_map_w
      $error("maxpool_relu: MAP_W must be even and nonzero");
   end
   if ((MAP_H % 2) != 0 || MAP_H < 2) begin : g_bad_map_h
      $error("maxpool_relu: MAP_H must be even and nonzero");
   end
   if (DATA_W != cnn_pkg::DATA_W) begin : g_bad_data_w
      $error("maxpool_relu: DATA_W must match the shared pipeline width");
   end

   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic           col_last;
   logic           row_last;
   logic [HCW-1:0] half_col;

   assign col_last = (col == CW'(MAP_W - 1));
   assign row_last = (row == RW'(MAP_H - 1));
   assign half_col = HCW'(col >> 1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= valid_in & col[0] & row[0];
         frame_done <= valid_in & col_last & row_last;
         if (valid_in) begin
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   logic signed [DATA_W-1:0] ch_in  [NUM_CH];
   logic signed [DATA_W-1:0] ch_out [NUM_CH];

   assign ch_in[0]   = conv_in_1;
   assign ch_in[1]   = conv_in_2;
   assign ch_in[2]   = conv_in_3;
   assign pool_out_1 = ch_out[0];
   assign pool_out_2 = ch_out[1];
   assign pool_out_3 = ch_out[2];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      maxpool_channel #(
         .MAP_W (MAP_W),
         .HCW   (HCW)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .valid_in (valid_in),
         .col_odd  (col[0]),
         .row_odd  (row[0]),
         .half_col (half_col),
         .sample   (ch_in[g]),
         .pool_out (ch_out[g])
      );
   end

endmodule

// File: tb/tb_maxpool_relu.sv
// Randomized bench for maxpool_relu against a whole-frame pooling model.
module tb_maxpool_relu;
   localparam int W = 24;
   localparam int H = 24;

   logic clk = 1'b0;
   logic rst_n;
   logic valid_in;
   logic signed [11:0] c1, c2, c3;
   logic signed [11:0] p1, p2, p3;
   logic valid_out, frame_done;

   always #5 clk = ~clk;

   maxpool_relu #(.DATA_W(12), .MAP_W(W), .MAP_H(H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .conv_in_1  (c1),
      .conv_in_2  (c2),
      .conv_in_3  (c3),
      .pool_out_1 (p1),
      .pool_out_2 (p2),
      .pool_out_3 (p3),
      .valid_out  (valid_out),
      .frame_done (frame_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Model: the whole current frame is kept, each window is pooled from it directly.
   int px [3][H][W];
   int mr = 0, mc = 0;
   int last_o [3] = '{0, 0, 0};
   logic nxt_v = 1'b0, nxt_fd = 1'b0;
   int nxt_o [3] = '{0, 0, 0};
   logic exp_v = 1'b0, exp_fd = 1'b0;
   int exp_o [3] = '{0, 0, 0};
   bit chk_en = 1'b0;

   int smp_cnt = 0;
   int out_cnt = 0;
   int fd_cnt = 0;
   int first_smp = -1;
   int fd_at = -1;
   int cap1[$], cap2[$], cap3[$];
   int cont[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      exp_v  <= nxt_v;
      exp_fd <= nxt_fd;
      exp_o  <= nxt_o;
      if (rst_n && valid_in) smp_cnt <= smp_cnt + 1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("valid_out", int'(valid_out), int'(exp_v));
         check("frame_done", int'(frame_done), int'(exp_fd));
         check("pool_out_1", int'(p1), exp_o[0]);
         check("pool_out_2", int'(p2), exp_o[1]);
         check("pool_out_3", int'(p3), exp_o[2]);
         if (valid_out === 1'b1) begin
            if (out_cnt == 0) first_smp = smp_cnt;
            out_cnt++;
            cap1.push_back(int'(p1));
            cap2.push_back(int'(p2));
            cap3.push_back(int'(p3));
            if (frame_done === 1'b1) begin
               fd_cnt++;
               fd_at = out_cnt;
            end
         end
      end
   end

   function automatic int rnd12();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic step(input bit r, input bit v, input int a, input int b, input int c);
      int s [3];
      int mx;
      s = '{a, b, c};
      rst_n    = r;
      valid_in = v;
      c1 = a[11:0];
      c2 = b[11:0];
      c3 = c[11:0];
      nxt_v  = 1'b0;
      nxt_fd = 1'b0;
      if (!r) begin
         mr = 0;
         mc = 0;
         last_o = '{0, 0, 0};
      end else if (v) begin
         for (int ch = 0; ch < 3; ch++) px[ch][mr][mc] = s[ch];
         if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            for (int ch = 0; ch < 3; ch++) begin
               mx = max2(max2(px[ch][mr-1][mc-1], px[ch][mr-1][mc]),
                         max2(px[ch][mr][mc-1], px[ch][mr][mc]));
               last_o[ch] = (mx < 0) ? 0 : mx;
            end
            nxt_v  = 1'b1;
            nxt_fd = (mr == H - 1) && (mc == W - 1);
         end
         mc++;
         if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
         end
      end
      nxt_o = last_o;
      @(posedge clk);
      #1;
   endtask

   // mode 0: constant 5; mode 1: ramp; mode 2: signed extremes in the first window, random elsewhere
   function automatic int pix(input int mode, input int ch, input int r, input int c);
      int ext1 [4];
      int ext2 [4];
      ext1 = '{-3, 4, -2048, 2047};
      ext2 = '{-1, -2, -2048, -5};
      case (mode)
         0: return 5;
         1: return (ch == 0) ? r * W + c : (ch == 1) ? -(r * W + c) : -7;
         default: begin
            if (r < 2 && c < 2 && ch < 2)
               return (ch == 0) ? ext1[r * 2 + c] : ext2[r * 2 + c];
            return rnd12();
         end
      endcase
   endfunction

   task automatic run_frame(input int mode, input bit bubbles, input int limit);
      int n = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (n >= limit) return;
            while (bubbles && $urandom_range(0, 99) < 50)
               step(1'b1, 1'b0, rnd12(), rnd12(), rnd12());
            step(1'b1, 1'b1, pix(mode, 0, r, c), pix(mode, 1, r, c), pix(mode, 2, r, c));
            n++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd12(), rnd12(), rnd12());
   endtask

   task automatic clear_log();
      out_cnt = 0;
      fd_cnt = 0;
      first_smp = -1;
      fd_at = -1;
      cap1.delete();
      cap2.delete();
      cap3.delete();
   endtask

   initial begin
      int base;
      int diffs;
      int mx2;
      int mx3;
      rst_n = 1'b0;
      valid_in = 1'b0;
      c1 = '0;
      c2 = '0;
      c3 = '0;
      chk_en = 1'b1;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd12(), rnd12(), rnd12());
      check("reset_valid_out", int'(valid_out), 0);
      check("reset_pool_out_1", int'(p1), 0);

      clear_log();
      base = smp_cnt;
      run_frame(0, 1'b0, W * H);
      idle(2);
      check("const_count", out_cnt, 144);
      check("const_first_pulse_input", first_smp - base, 26);
      check("const_fd_count", fd_cnt, 1);
      check("const_fd_on_pulse", fd_at, 144);
      check("const_value", cap2[0], 5);

      clear_log();
      run_frame(1, 1'b0, W * H);
      idle(2);
      check("ramp_count", out_cnt, 144);
      check("ramp_first", cap1[0], 25);
      check("ramp_second", cap1[1], 27);
      check("ramp_row2_first", cap1[12], 73);
      check("ramp_last", cap1[143], 575);
      mx2 = 0;
      mx3 = 0;
      foreach (cap2[i]) begin
         mx2 = max2(mx2, cap2[i]);
         mx3 = max2(mx3, cap3[i]);
      end
      check("ramp_ch2_zero", mx2, 0);
      check("ramp_ch3_zero", mx3, 0);
      cont = cap1;

      clear_log();
      run_frame(2, 1'b0, W * H);
      idle(2);
      check("extreme_ch1", cap1[0], 2047);
      check("extreme_ch2", cap2[0], 0);

      clear_log();
      run_frame(1, 1'b1, W * H);
      idle(3);
      check("bubble_count", out_cnt, 144);
      diffs = 0;
      foreach (cont[i]) if (cap1[i] != cont[i]) diffs++;
      check("bubble_seq_diffs", diffs, 0);

      run_frame(1, 1'b0, 100);
      step(1'b0, 1'b1, rnd12(), rnd12(), rnd12());
      step(1'b0, 1'b1, rnd12(), rnd12(), rnd12());
      clear_log();
      run_frame(1, 1'b0, W * H);
      run_frame(1, 1'b0, W * H);
      idle(2);
      check("midreset_count", out_cnt, 288);
      check("midreset_fd_count", fd_cnt, 2);
      check("midreset_first", cap1[0], 25);
      check("midreset_second_frame_first", cap1[144], 25);
      check("midreset_last", cap1[287], 575);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
